// File: rtl/tank_trouble_soc_keys_in_pio.sv
// Avalon-MM input PIO: sync, optional debounce, sticky edge capture, masked IRQ.
// Optional debounce filter: define KEYS_PIO_DEBOUNCE_EN.
module tank_trouble_soc_keys_in_pio #(
  parameter int WIDTH           = 4,
  parameter bit EDGE_FALLING    = 1'b1,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] s1_q, s2_q, fd_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [WIDTH-1:0] f, edg, clr;
  logic             wr;
  logic             unused_ok;

  assign wr        = chipselect & ~write_n;
  assign unused_ok = ^writedata;

`ifdef KEYS_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] f_q, f_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // A bit is accepted only after s2 disagrees with f for the full window
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          f_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q <= IDLE;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      f_q <= f_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign f = f_q;
`else
  assign f = s2_q;
`endif

  always_comb begin
    edg    = EDGE_FALLING ? (fd_q & ~f) : (~fd_q & f);
    clr    = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    ecap_d = (ecap_q & ~clr) | edg;
    mask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= IDLE;
      s2_q   <= IDLE;
      fd_q   <= IDLE;
      mask_q <= '0;
      ecap_q <= '0;
    end else begin
      s1_q   <= in_port;
      s2_q   <= s1_q;
      fd_q   <= f;
      mask_q <= mask_d;
      ecap_q <= ecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = f;
      2'd2:    readdata[WIDTH-1:0] = mask_q;
      2'd3:    readdata[WIDTH-1:0] = ecap_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(ecap_q & mask_q);

endmodule

// File: tb/tb_tank_trouble_soc_keys_in_pio.sv
// Bench for tank_trouble_soc_keys_in_pio: directed scenarios plus random
// bus/input traffic against a sample-history reference model.
module tb_tank_trouble_soc_keys_in_pio;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] in_port = '1;
  logic         irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tank_trouble_soc_keys_in_pio #(
    .WIDTH(W), .EDGE_FALLING(1'b1), .IDLE_LEVEL(1'b1), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  // Model: h[0] is the newest clocked sample of in_port; the visible level
  // is the sample two clocks old, and a capture is a 1->0 step in it.
  logic [W-1:0] h [3];
  logic [W-1:0] m_mask, m_ecap, m_ev, m_clr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h[0] = '1; h[1] = '1; h[2] = '1;
      m_mask = '0; m_ecap = '0;
    end else begin
      m_ev  = h[2] & ~h[1];
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      m_ecap = (m_ecap & ~m_clr) | m_ev;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      h[2] = h[1]; h[1] = h[0]; h[0] = in_port;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    exp_rd = '0;
    case (a)
      2'd0: exp_rd[W-1:0] = h[1];
      2'd2: exp_rd[W-1:0] = m_mask;
      2'd3: exp_rd[W-1:0] = m_ecap;
      default: exp_rd = '0;
    endcase
  endfunction

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic settle_clear();
    @(negedge clk);
    in_port = '1;
    repeat (5) @(negedge clk);
    wr(2'd3, 32'hF);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    in_port = 4'b0101;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL reset_data got=%h exp=%h", d, 32'hF); end
    rd(2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got=%h exp=0", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ecap got=%h exp=0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
`ifndef KEYS_PIO_DEBOUNCE_EN
    @(negedge clk); @(negedge clk);
    rd(2'd0, d); checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL reset_data2 got=%h exp=5", d); end
`endif
  endtask

  task automatic test_fall_capture();
    logic [31:0] d;
    settle_clear();
    wr(2'd2, 32'h1);
    in_port[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    rd(2'd3, d); checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL fall_early ecap=%h irq=%b exp=0/0", d, irq);
    end
    @(negedge clk);
    rd(2'd3, d); checks++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      errors++; $display("FAIL fall_capture ecap=%h irq=%b exp=1/1", d, irq);
    end
    wr(2'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL fall_w1c irq=%b exp=0", irq); end
  endtask

  task automatic test_mask_w1c();
    logic [31:0] d;
    settle_clear();
    wr(2'd2, 32'h0);
    in_port = 4'b1001;
    repeat (4) @(negedge clk);
    rd(2'd3, d); checks++;
    if (d !== 32'h6 || irq !== 1'b0) begin
      errors++; $display("FAIL mask_edges ecap=%h irq=%b exp=6/0", d, irq);
    end
    wr(2'd3, 32'h2);
    rd(2'd3, d); checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL w1c_partial got=%h exp=4", d); end
    wr(2'd2, 32'h4);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL mask_enable irq=%b exp=1", irq); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    settle_clear();
    in_port[3] = 1'b0;
    @(negedge clk); @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h8;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(2'd3, d); checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL set_wins got=%h exp=8", d); end
  endtask

  task automatic test_bus_hygiene();
    logic [31:0] d;
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL dir_read got=%h exp=0", d); end
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, d); checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL mask_width got=%h exp=f", d); end
    wr(2'd0, 32'h0);
    rd(2'd0, d); checks++;
    if (d !== exp_rd(2'd0)) begin errors++; $display("FAIL data_ro got=%h exp=%h", d, exp_rd(2'd0)); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'($urandom);
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = $urandom_range(0, 1) == 1;
      writedata  = $urandom;
      address    = 2'($urandom);
      #1;
      e = exp_rd(address);
      checks++;
      if (readdata !== e || irq !== |(m_ecap & m_mask)) begin
        errors++;
        $display("FAIL random[%0d] a=%0d rd=%h exp=%h irq=%b exp=%b",
                 n, address, readdata, e, irq, |(m_ecap & m_mask));
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    int n;
    settle_clear();
    repeat (40) @(negedge clk);
    wr(2'd3, 32'hF);
    in_port[0] = 1'b0;
    repeat (10) @(negedge clk);
    in_port[0] = 1'b1;
    repeat (30) @(negedge clk);
    rd(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL glitch_data got=%h exp=f", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_ecap got=%h exp=0", d); end
    in_port[0] = 1'b0;
    n = 0;
    d = '0;
    while (d[0] !== 1'b1 && n < 25) begin
      @(negedge clk);
      n++;
      rd(2'd3, d);
    end
    checks++;
    if (d[0] !== 1'b1 || n > 19) begin
      errors++; $display("FAIL debounce_latency cycles=%0d ecap=%h exp<=19/1", n, d);
    end
  endtask

  initial begin
    test_reset();
`ifdef KEYS_PIO_DEBOUNCE_EN
    test_debounce();
`else
    test_fall_capture();
    test_mask_w1c();
    test_set_wins();
    test_bus_hygiene();
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
